// File: rtl/mips_mem_bus.sv
// Memory-side terminator for the multicycle MIPS core's load/store port.
// Word accesses go to a synchronous data RAM or to LED/SW/CYCLES MMIO registers.
module mips_mem_bus #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE = 32'h0000_4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_fault,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  // state  | meaning
  // IDLE   | waiting for mem_req; request latched and decoded on accept
  // ACCESS | RAM address/strobe driven, MMIO read sampled or store committed
  // RDWAIT | registered RAM data arriving, captured into rdata
  // DONE   | one-cycle mem_ready with rdata and fault
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;
  typedef enum logic [2:0] {K_RAM, K_LED, K_SW, K_CYC, K_FAULT} kind_t;

  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'd4 << RAM_AW);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [15:0]       sw_meta_q, sw_meta_d;
  logic [15:0]       sw_sync_q, sw_sync_d;

  logic [31:0]       ram_off;
  logic              ram_hit;
  kind_t             kind_dec;
  logic              unused_off;

  always_comb begin
    ram_off  = mem_addr - RAM_BASE;
    ram_hit  = (mem_addr >= RAM_BASE) && ({1'b0, mem_addr} < RAM_END);
    kind_dec = K_FAULT;
    if (mem_addr[1:0] != 2'b00)               kind_dec = K_FAULT;
    else if (ram_hit)                         kind_dec = K_RAM;
    else if (mem_addr == MMIO_BASE)           kind_dec = K_LED;
    else if (mem_addr == MMIO_BASE + 32'd4)   kind_dec = K_SW;
    else if (mem_addr == MMIO_BASE + 32'd8)   kind_dec = K_CYC;
  end

  // Only the in-range word index of the RAM offset is meaningful.
  assign unused_off = ^{ram_off[31:RAM_AW+2], ram_off[1:0]};

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr_q;
    rdata_d    = rdata_q;
    led_d      = led_q;
    cyc_d      = cyc_q + 32'd1;
    sw_meta_d  = sw_in;
    sw_sync_d  = sw_meta_q;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          kind_d     = kind_dec;
          we_d       = mem_we;
          wdata_d    = mem_wdata;
          ram_addr_d = ram_off[RAM_AW+1:2];
          rdata_d    = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = '0;
        state_d = DONE;
        if (kind_q == K_RAM && !we_q) begin
          state_d = RDWAIT;
        end else if (we_q) begin
          if (kind_q == K_LED) led_d = wdata_q[15:0];
          // A CYCLES store wins over this cycle's increment.
          if (kind_q == K_CYC) cyc_d = '0;
        end else begin
          case (kind_q)
            K_LED:   rdata_d = {16'b0, led_q};
            K_SW:    rdata_d = {16'b0, sw_sync_q};
            K_CYC:   rdata_d = cyc_q;
            default: rdata_d = '0;
          endcase
        end
      end
      RDWAIT: begin
        rdata_d = ram_rdata;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      kind_q     <= K_FAULT;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ram_addr_q <= '0;
      rdata_q    <= '0;
      led_q      <= '0;
      cyc_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ram_addr_q <= ram_addr_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      cyc_q      <= cyc_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

  assign mem_ready = (state_q == DONE);
  assign mem_fault = (state_q == DONE) && (kind_q == K_FAULT);
  assign mem_rdata = (state_q == DONE) ? rdata_q : 32'd0;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;
  // Gated by rst so a store caught in ACCESS is not written at the reset edge.
  assign ram_we    = rst && (state_q == ACCESS) && (kind_q == K_RAM) && we_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mips_mem_bus.sv
// Directed bench for mips_mem_bus: RAM/MMIO/fault accesses, latency, counter and reset abort.
module tb_mips_mem_bus;
  localparam int          RAM_AW    = 10;
  localparam logic [31:0] RAM_BASE  = 32'h0000_2000;
  localparam logic [31:0] MMIO_BASE = 32'h0000_4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_ready, mem_fault;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [15:0]       sw_in, led_out;

  int checks = 0;
  int passed = 0;

  int                we_pulses;
  logic [RAM_AW-1:0] we_addr;
  logic [31:0]       r_data;
  logic              r_fault;
  int                r_lat;

  logic [31:0] ram_mem [0:(1<<RAM_AW)-1];

  mips_mem_bus #(.RAM_AW(RAM_AW), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_fault(mem_fault),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1<<RAM_AW); i++) ram_mem[i] = 32'd0;
    ram_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Counts edges from the sampling edge up to the ready cycle; scrambles inputs after sampling.
  task automatic wait_ready();
    int n;
    n = 0;
    we_pulses = 0;
    we_addr = '0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (ram_we) begin we_pulses++; we_addr = ram_addr; end
      if (n == 1) begin
        mem_addr  = 32'h0000_8000;
        mem_we    = ~mem_we;
        mem_wdata = ~mem_wdata;
      end
      if (mem_ready) break;
    end
    r_lat   = n;
    r_data  = mem_rdata;
    r_fault = mem_fault;
    mem_req = 1'b0;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    wait_ready();
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0; sw_in = 16'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = MMIO_BASE + 32'd8; mem_wdata = 32'd0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ready || ram_we || mem_fault) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL reset_quiet: got %0d active cycles want 0", bad); else passed++;
    checks++; if (led_out !== 16'h0) $display("FAIL reset_led: got %h want 0000", led_out); else passed++;
    checks++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", mem_rdata); else passed++;
    @(negedge clk); rst = 1'b1;
    wait_ready();
    checks++; if (r_lat !== 2) $display("FAIL reset_cyc_lat: got %0d want 2", r_lat); else passed++;
    checks++; if (r_data !== 32'd1) $display("FAIL reset_cyc_val: got %h want 1", r_data); else passed++;
    checks++; if (r_fault !== 1'b0) $display("FAIL reset_cyc_fault: got %b want 0", r_fault); else passed++;
  endtask

  task automatic test_ram();
    access(1'b1, RAM_BASE + 32'd8, 32'hDEAD_BEEF);
    checks++; if (r_lat !== 2) $display("FAIL ram_st_lat: got %0d want 2", r_lat); else passed++;
    checks++; if (we_pulses !== 1) $display("FAIL ram_st_pulses: got %0d want 1", we_pulses); else passed++;
    checks++; if (we_addr !== 10'd2) $display("FAIL ram_st_addr: got %0d want 2", we_addr); else passed++;
    checks++; if (r_data !== 32'd0 || r_fault !== 1'b0) $display("FAIL ram_st_resp: got %h/%b want 0/0", r_data, r_fault); else passed++;
    access(1'b0, RAM_BASE + 32'd8, 32'h0);
    checks++; if (r_lat !== 3) $display("FAIL ram_ld_lat: got %0d want 3", r_lat); else passed++;
    checks++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL ram_ld_data: got %h want deadbeef", r_data); else passed++;
    checks++; if (r_fault !== 1'b0 || we_pulses !== 0) $display("FAIL ram_ld_side: got fault %b we %0d want 0/0", r_fault, we_pulses); else passed++;
    access(1'b1, RAM_BASE + 32'h0000_0FFC, 32'h0BAD_F00D);
    checks++; if (we_addr !== 10'd1023 || we_pulses !== 1) $display("FAIL ram_top_st: got addr %0d n %0d want 1023/1", we_addr, we_pulses); else passed++;
    access(1'b0, RAM_BASE + 32'h0000_0FFC, 32'h0);
    checks++; if (r_data !== 32'h0BAD_F00D) $display("FAIL ram_top_ld: got %h want 0badf00d", r_data); else passed++;
  endtask

  task automatic test_mmio();
    access(1'b1, MMIO_BASE, 32'h1234_A5A5);
    checks++; if (r_lat !== 2 || r_fault !== 1'b0) $display("FAIL led_st: got lat %0d fault %b want 2/0", r_lat, r_fault); else passed++;
    checks++; if (led_out !== 16'hA5A5) $display("FAIL led_out: got %h want a5a5", led_out); else passed++;
    access(1'b0, MMIO_BASE, 32'h0);
    checks++; if (r_data !== 32'h0000_A5A5) $display("FAIL led_ld: got %h want 0000a5a5", r_data); else passed++;
    @(negedge clk); sw_in = 16'h00F0;
    access(1'b0, MMIO_BASE + 32'd4, 32'h0);
    checks++; if (r_data !== 32'h0000_00F0) $display("FAIL sw_ld: got %h want 000000f0", r_data); else passed++;
    access(1'b1, MMIO_BASE + 32'd4, 32'h0000_FFFF);
    checks++; if (r_fault !== 1'b0 || r_lat !== 2) $display("FAIL sw_st: got fault %b lat %0d want 0/2", r_fault, r_lat); else passed++;
    checks++; if (led_out !== 16'hA5A5) $display("FAIL sw_st_led: got %h want a5a5", led_out); else passed++;
  endtask

  task automatic test_faults();
    access(1'b0, RAM_BASE + 32'd1, 32'h0);
    checks++; if (r_lat !== 2 || r_fault !== 1'b1) $display("FAIL misalign: got lat %0d fault %b want 2/1", r_lat, r_fault); else passed++;
    checks++; if (r_data !== 32'd0 || we_pulses !== 0) $display("FAIL misalign_side: got %h we %0d want 0/0", r_data, we_pulses); else passed++;
    access(1'b0, 32'h0000_8000, 32'h0);
    checks++; if (r_lat !== 2 || r_fault !== 1'b1 || r_data !== 32'd0) $display("FAIL unmapped: got lat %0d fault %b data %h want 2/1/0", r_lat, r_fault, r_data); else passed++;
    access(1'b1, RAM_BASE + 32'h0000_1000, 32'h0000_0055);
    checks++; if (r_fault !== 1'b1 || we_pulses !== 0) $display("FAIL ram_end: got fault %b we %0d want 1/0", r_fault, we_pulses); else passed++;
    access(1'b1, MMIO_BASE + 32'd1, 32'h0000_FFFF);
    checks++; if (r_fault !== 1'b1 || led_out !== 16'hA5A5) $display("FAIL mmio_misalign: got fault %b led %h want 1/a5a5", r_fault, led_out); else passed++;
    access(1'b0, MMIO_BASE + 32'd12, 32'h0);
    checks++; if (r_fault !== 1'b1) $display("FAIL mmio_hole: got fault %b want 1", r_fault); else passed++;
  endtask

  task automatic test_cycles();
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    @(posedge clk); #1;
    checks++; if (dut.cyc_q !== 32'd0) $display("FAIL cyc_wrap: got %h want 0", dut.cyc_q); else passed++;
    access(1'b0, MMIO_BASE + 32'd8, 32'h0);
    checks++; if (r_data !== 32'd2) $display("FAIL cyc_after_wrap: got %h want 2", r_data); else passed++;
    access(1'b1, MMIO_BASE + 32'd8, 32'h0);
    checks++; if (r_fault !== 1'b0 || r_lat !== 2) $display("FAIL cyc_clr: got fault %b lat %0d want 0/2", r_fault, r_lat); else passed++;
    access(1'b0, MMIO_BASE + 32'd8, 32'h0);
    checks++; if (r_data !== 32'd2) $display("FAIL cyc_since_clr: got %h want 2", r_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pattern;
    pattern = '0;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = MMIO_BASE; mem_wdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pattern[i] = mem_ready;
    end
    mem_req = 1'b0;
    checks++; if (pattern !== 8'h92) $display("FAIL b2b_ready: got %b want 10010010", pattern); else passed++;
  endtask

  task automatic test_reset_abort();
    int bad;
    bad = 0;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = RAM_BASE + 32'd8; mem_wdata = 32'h0;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready || ram_we) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", bad); else passed++;
    checks++; if (led_out !== 16'h0) $display("FAIL abort_led: got %h want 0000", led_out); else passed++;
    @(negedge clk); rst = 1'b1;
    access(1'b0, RAM_BASE + 32'd8, 32'h0);
    checks++; if (r_lat !== 3 || r_data !== 32'hDEAD_BEEF) $display("FAIL abort_next: got lat %0d data %h want 3/deadbeef", r_lat, r_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_mmio();
    test_faults();
    test_cycles();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

endmodule
